// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequence checker: opcodes, FSM encoding,
// vector count and the reference result function used by the vector ROM.
package alu_pkg;

    localparam int VEC_COUNT = 8;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_MUL  = 3'd2;
    localparam logic [2:0] OP_AND  = 3'd3;
    localparam logic [2:0] OP_OR   = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_NAND = 3'd6;
    localparam logic [2:0] OP_NOTA = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRIVE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // 8-bit result from zero-extended 4-bit operands; logic ops keep the upper nibble clear
    function automatic logic [7:0] alu_expected(input logic [3:0] a,
                                                input logic [3:0] b,
                                                input logic [2:0] s);
        logic [7:0] ax;
        logic [7:0] bx;
        logic [7:0] r;
        ax = {4'h0, a};
        bx = {4'h0, b};
        case (s)
            OP_ADD:  r = ax + bx;
            OP_SUB:  r = ax - bx;
            OP_MUL:  r = ax * bx;
            OP_AND:  r = ax & bx;
            OP_OR:   r = ax | bx;
            OP_XOR:  r = ax ^ bx;
            OP_NAND: r = {4'h0, ~(a & b)};
            OP_NOTA: r = {4'h0, ~a};
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_vec_rom.sv
// Fixed table of eight test vectors for the ALU under test, with the
// expected result derived from the shared reference function.
module alu_vec_rom
    import alu_pkg::*;
(
    input  logic [2:0] idx,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [2:0] s,
    output logic [7:0] expected
);

    // Vector lookup; each vector exercises a distinct opcode
    always_comb begin
        a = 4'd0;
        b = 4'd0;
        s = OP_ADD;
        case (idx)
            3'd0: begin a = 4'd9;  b = 4'd3;  s = OP_ADD;  end
            3'd1: begin a = 4'd9;  b = 4'd11; s = OP_SUB;  end
            3'd2: begin a = 4'd9;  b = 4'd7;  s = OP_MUL;  end
            3'd3: begin a = 4'd13; b = 4'd11; s = OP_AND;  end
            3'd4: begin a = 4'd11; b = 4'd7;  s = OP_OR;   end
            3'd5: begin a = 4'd10; b = 4'd11; s = OP_XOR;  end
            3'd6: begin a = 4'd14; b = 4'd7;  s = OP_NAND; end
            3'd7: begin a = 4'd5;  b = 4'd11; s = OP_NOTA; end
            default: begin a = 4'd0; b = 4'd0; s = OP_ADD; end
        endcase
        expected = alu_expected(a, b, s);
    end

endmodule

// File: rtl/alu_seq_checker.sv
// Drives eight fixed vectors into an external ALU, waits SETTLE cycles per
// vector, compares the returned result and reports pass/err_cnt/fail_idx.
module alu_seq_checker
    import alu_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [3:0] a_o,
    output logic [3:0] b_o,
    output logic [2:0] s_o,
    input  logic [7:0] y_i,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] err_cnt,
    output logic [2:0] fail_idx
);

    // WAIT is unreachable when SETTLE is 0, so the terminal count is only meaningful otherwise
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;
    localparam logic [3:0] ERR_MAX     = 4'd8;
    localparam logic [2:0] IDX_LAST    = 3'(VEC_COUNT - 1);

    state_t     state_r, state_s;
    logic [2:0] idx_r, idx_s;
    logic [3:0] wcnt_r, wcnt_s;
    logic [3:0] a_r, a_s;
    logic [3:0] b_r, b_s;
    logic [2:0] s_r, s_s;
    logic       busy_r, busy_s;
    logic       done_r, done_s;
    logic       pass_r, pass_s;
    logic [3:0] err_r, err_s;
    logic [2:0] fail_r, fail_s;

    logic [3:0] rom_a_s;
    logic [3:0] rom_b_s;
    logic [2:0] rom_s_s;
    logic [7:0] rom_exp_s;
    logic       mismatch_s;

    alu_vec_rom u_rom (
        .idx      (idx_r),
        .a        (rom_a_s),
        .b        (rom_b_s),
        .s        (rom_s_s),
        .expected (rom_exp_s)
    );

    assign mismatch_s = (y_i != rom_exp_s);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-value logic for the sequencer and its outputs
    always_comb begin
        state_s = state_r;
        idx_s   = idx_r;
        wcnt_s  = wcnt_r;
        a_s     = a_r;
        b_s     = b_r;
        s_s     = s_r;
        pass_s  = pass_r;
        err_s   = err_r;
        fail_s  = fail_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_DRIVE;
                    idx_s   = 3'd0;
                    err_s   = 4'd0;
                    fail_s  = 3'd0;
                    pass_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                a_s    = rom_a_s;
                b_s    = rom_b_s;
                s_s    = rom_s_s;
                wcnt_s = 4'd0;
                if (SETTLE != 0) begin
                    state_s = ST_WAIT;
                end else begin
                    state_s = ST_CHECK;
                end
            end
            ST_WAIT: begin
                if (wcnt_r == SETTLE_LAST) begin
                    state_s = ST_CHECK;
                end else begin
                    wcnt_s = wcnt_r + 4'd1;
                end
            end
            ST_CHECK: begin
                if (mismatch_s) begin
                    if (err_r != ERR_MAX) begin
                        err_s = err_r + 4'd1;
                    end else begin
                        err_s = err_r;
                    end
                    if (err_r == 4'd0) begin
                        fail_s = idx_r;
                    end else begin
                        fail_s = fail_r;
                    end
                end else begin
                    err_s = err_r;
                end
                if (idx_r == IDX_LAST) begin
                    state_s = ST_DONE;
                    pass_s  = (err_s == 4'd0);
                end else begin
                    idx_s   = idx_r + 3'd1;
                    state_s = ST_DRIVE;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
        busy_s = (state_s == ST_DRIVE) || (state_s == ST_WAIT) || (state_s == ST_CHECK);
        done_s = (state_s == ST_DONE);
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_r  <= 3'd0;
            wcnt_r <= 4'd0;
            a_r    <= 4'd0;
            b_r    <= 4'd0;
            s_r    <= 3'd0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            pass_r <= 1'b0;
            err_r  <= 4'd0;
            fail_r <= 3'd0;
        end else begin
            idx_r  <= idx_s;
            wcnt_r <= wcnt_s;
            a_r    <= a_s;
            b_r    <= b_s;
            s_r    <= s_s;
            busy_r <= busy_s;
            done_r <= done_s;
            pass_r <= pass_s;
            err_r  <= err_s;
            fail_r <= fail_s;
        end
    end

    assign a_o      = a_r;
    assign b_o      = b_r;
    assign s_o      = s_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign pass     = pass_r;
    assign err_cnt  = err_r;
    assign fail_idx = fail_r;

endmodule

// File: doc/alu_seq_checker.md
ALU_SEQ_CHECKER -- requirements
Module: alu_seq_checker

Interface
REQ-001 Parameter: SETTLE, default 2, number of wait cycles between driving operands and sampling the result (legal range 0..15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  run request; sampled only in IDLE.
REQ-005 a_o  output  4  operand A driven to the ALU under test.
REQ-006 b_o  output  4  operand B driven to the ALU under test.
REQ-007 s_o  output  3  opcode driven to the ALU under test.
REQ-008 y_i  input  8  ALU result returned from the ALU under test.
REQ-009 busy  output  1  high from the DRIVE of vector 0 through the last CHECK.
REQ-010 done  output  1  one-cycle pulse at end of run.
REQ-011 pass  output  1  high when the last completed run had zero mismatches; held until next run starts.
REQ-012 err_cnt  output  4  mismatch count of current/last run.
REQ-013 fail_idx  output  3  index of first mismatching vector; 0 if none.

Function
REQ-014 The FSM SHALL have states IDLE, DRIVE, WAIT, CHECK, DONE.
REQ-015 IDLE + start=1 SHALL go to DRIVE with idx=0, err_cnt=0, fail_idx=0, pass=0.
REQ-016 DRIVE SHALL register a_o/b_o/s_o from vector[idx]; next state WAIT if SETTLE>0, else CHECK.
REQ-017 WAIT SHALL last exactly SETTLE cycles, then go to CHECK; operands held stable.
REQ-018 CHECK SHALL compare y_i to expected[idx]; on mismatch err_cnt increments and, if first mismatch, fail_idx=idx.
REQ-019 CHECK with idx=7 SHALL go to DONE; otherwise idx increments and the FSM returns to DRIVE.
REQ-020 DONE SHALL last one cycle with done=1, pass=(err_cnt==0), then return to IDLE; operands keep their last values.
REQ-021 Each vector SHALL take SETTLE+2 cycles; done SHALL be high in cycle 8*(SETTLE+2)+1 after the edge that samples start.
REQ-022 start SHALL be ignored in every state other than IDLE, including DONE.
REQ-023 Expected values SHALL be computed on 8 bits from zero-extended operands: 000 a+b; 001 a-b (two's complement, mod 256); 010 a*b; 011 a&b; 100 a|b; 101 a^b; 110 {4'h0, ~(a&b)}; 111 {4'h0, ~a}.
REQ-024 Vector table (a,b,s) idx0..7 SHALL be: (9,3,0) (9,11,1) (9,7,2) (13,11,3) (11,7,4) (10,11,5) (14,7,6) (5,11,7); expected 0x0C 0xFE 0x3F 0x09 0x0F 0x01 0x09 0x0A.
REQ-025 err_cnt SHALL be unable to exceed 8; no wrap.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, idx=0, a_o=b_o=s_o=0, busy=0, done=0, pass=0, err_cnt=0, fail_idx=0.
REQ-027 Reset mid-run SHALL abort the run with no done pulse; the next start begins a fresh run from idx 0.

Structure
REQ-028 Package alu_pkg SHALL hold opcode constants, the expected-value function of REQ-023, vector count (8) and the FSM state encoding.
REQ-029 The vector table SHALL be a combinational sub-module alu_vec_rom (input idx[2:0]; outputs a, b, s, expected).
REQ-030 Total RTL SHALL be a single registered FSM plus alu_vec_rom; no combinational path from y_i to any output.

Verification
REQ-031 Correct ALU model on y_i, SETTLE=2, one start pulse -> done in cycle 33, pass=1, err_cnt=0, fail_idx=0.
REQ-032 y_i tied to 0x00 -> err_cnt=8, fail_idx=0, pass=0 at done.
REQ-033 Model faulted only for s=001 (returns 0x02) -> err_cnt=1, fail_idx=1, pass=0.
REQ-034 rst asserted in cycle 10 of a run -> all outputs 0 same cycle, no done; restart with correct model -> pass=1.
REQ-035 start held high continuously -> runs back-to-back, each new run beginning only from IDLE after done; no start effect while busy.
REQ-036 SETTLE=0, correct model -> done in cycle 17, pass=1; y_i sampled in the cycle after each DRIVE.
